// File: rtl/lsb_queue_if.sv
// Memory-controller port of the load/store queue: one request in flight, completed by mem_done.
interface lsb_queue_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    input  mem_done, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store queue: head entry issues to memory, loads broadcast on the CDB, committed stores survive a flush.
// Optional macro LSB_IO_ORDER_EN: loads to addr[17:16]==2'b11 wait until their tag reaches the ROB head.
module lsb_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [3:0]         in_op,
  input  logic [31:0]        in_base,
  input  logic [31:0]        in_imm,
  input  logic [31:0]        in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               full,
  input  logic               commit,
  input  logic [TAG_W-1:0]   rob_head_tag,
  lsb_queue_if.master        mem,
  output logic               cdb_valid,
  output logic [TAG_W-1:0]   cdb_tag,
  output logic [31:0]        cdb_data
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t           state;
  logic [3:0]       op_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [PTR_W-1:0] head, tail, head_n;
  logic [PTR_W:0]   count, cstore, count_n, cstore_n;

  logic [3:0]       h_op;
  logic [31:0]      h_addr, h_data, wdata_m, rdata_x;
  logic [TAG_W-1:0] h_tag;
  logic [2:0]       len;
  logic             h_legal, h_eligible, io_ok;
  logic             enq, deq, store_done, issue;

  assign full = (count >= (PTR_W+1)'(DEPTH - 1));

`ifdef LSB_IO_ORDER_EN
  assign io_ok = (h_addr[17:16] != 2'b11) || (h_tag == rob_head_tag);
`else
  logic unused_rob_tag;
  assign unused_rob_tag = ^rob_head_tag;
  assign io_ok = 1'b1;
`endif

  always_comb begin
    h_op    = op_q[head];
    h_addr  = addr_q[head];
    h_data  = data_q[head];
    h_tag   = tag_q[head];
    h_legal = h_op[3] ? (h_op[2:0] inside {3'd0, 3'd1, 3'd2})
                      : (h_op[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    h_eligible = h_legal && (h_op[3] ? (cstore != '0) : io_ok);

    case (h_op[1:0])
      2'b00:   begin len = 3'd1; wdata_m = {24'b0, h_data[7:0]};  end
      2'b01:   begin len = 3'd2; wdata_m = {16'b0, h_data[15:0]}; end
      default: begin len = 3'd4; wdata_m = h_data;                end
    endcase
    // funct3[2] selects zero extension (BU/HU).
    case (h_op[1:0])
      2'b00:   rdata_x = {{24{mem.mem_rdata[7]  & ~h_op[2]}}, mem.mem_rdata[7:0]};
      2'b01:   rdata_x = {{16{mem.mem_rdata[15] & ~h_op[2]}}, mem.mem_rdata[15:0]};
      default: rdata_x = mem.mem_rdata;
    endcase

    store_done = (state == WAIT) && mem.mem_done && mem.mem_we;
    issue      = (state == IDLE) && !clear && (count != '0) && h_eligible;
    deq        = store_done
              || ((state == WAIT) && mem.mem_done && !mem.mem_we && !clear)
              || ((state == IDLE) && !clear && (count != '0) && !h_legal);
    enq        = in_valid && !clear && (count != (PTR_W+1)'(DEPTH));

    cstore_n = cstore + (PTR_W+1)'(commit) - (PTR_W+1)'(store_done);
    count_n  = count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    head_n   = head + PTR_W'(deq);
  end

  // NOTE: queue storage carries no reset; head/tail/count already mark every slot invalid after reset.
  always_ff @(posedge clk) begin
    if (rdy && enq) begin
      op_q[tail]   <= in_op;
      addr_q[tail] <= in_base + in_imm;
      data_q[tail] <= in_data;
      tag_q[tail]  <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      cstore        <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_len   <= '0;
      mem.mem_wdata <= '0;
      cdb_valid     <= 1'b0;
      cdb_tag       <= '0;
      cdb_data      <= '0;
    end else if (rdy) begin
      head      <= head_n;
      cstore    <= cstore_n;
      cdb_valid <= 1'b0;
      // A flush keeps exactly the committed stores counted from the (post-dequeue) head.
      if (clear) begin
        tail  <= head_n + cstore_n[PTR_W-1:0];
        count <= cstore_n;
      end else begin
        tail  <= tail + PTR_W'(enq);
        count <= count_n;
      end

      case (state)
        IDLE: if (issue) begin
          state         <= WAIT;
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= h_op[3];
          mem.mem_addr  <= h_addr;
          mem.mem_len   <= len;
          mem.mem_wdata <= wdata_m;
        end
        WAIT: if (mem.mem_done) begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
          if (!mem.mem_we && !clear) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= h_tag;
            cdb_data  <= rdata_x;
          end
        end else if (clear && !mem.mem_we) begin
          state       <= DRAIN;
          mem.mem_req <= 1'b0;
        end
        DRAIN: if (mem.mem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue (DEPTH=4): loads, stores, full/wrap, flush, drain, reset and IO ordering.
module tb_lsb_queue;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, in_valid, commit;
  logic [3:0]  in_op, in_tag, rob_head_tag, cdb_tag;
  logic [31:0] in_base, in_imm, in_data, cdb_data;
  logic        full, cdb_valid;
  int          vectors = 0;
  int          miscompares = 0;

  lsb_queue_if bus();

  lsb_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_op(in_op), .in_base(in_base), .in_imm(in_imm),
    .in_data(in_data), .in_tag(in_tag), .full(full), .commit(commit),
    .rob_head_tag(rob_head_tag), .mem(bus.master),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] data, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_base = base; in_imm = imm; in_data = data; in_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 50) begin tick(); n++; end
    vectors++;
    if (bus.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_req: mem_req=%b after 50 cycles, required 1", name, bus.mem_req);
    end
  endtask

  task automatic serve(input string name, input logic we, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] wdata, input logic [31:0] rdata);
    wait_req(name);
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_len} !== {we, addr, len}) begin
      miscompares++;
      $display("FAIL %s_fields: we=%b addr=%h len=%0d, required we=%b addr=%h len=%0d",
               name, bus.mem_we, bus.mem_addr, bus.mem_len, we, addr, len);
    end
    if (we) begin
      vectors++;
      if (bus.mem_wdata !== wdata) begin
        miscompares++;
        $display("FAIL %s_wdata: got %h, required %h", name, bus.mem_wdata, wdata);
      end
    end
    tick(); tick();
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr) begin
      miscompares++;
      $display("FAIL %s_hold: req=%b addr=%h, required req=1 addr=%h", name, bus.mem_req, bus.mem_addr, addr);
    end
    bus.mem_rdata = rdata; bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    vectors++;
    if (bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drop: mem_req=%b after done, required 0", name, bus.mem_req);
    end
  endtask

  task automatic expect_cdb(input string name, input logic valid, input logic [3:0] tag, input logic [31:0] data);
    vectors++;
    if (cdb_valid !== valid || (valid && (cdb_tag !== tag || cdb_data !== data))) begin
      miscompares++;
      $display("FAIL %s_cdb: valid=%b tag=%h data=%h, required valid=%b tag=%h data=%h",
               name, cdb_valid, cdb_tag, cdb_data, valid, tag, data);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.mem_req !== 1'b0 || cdb_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_quiet: activity seen=%b, required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; commit = 1'b0;
    in_op = '0; in_tag = '0; in_base = '0; in_imm = '0; in_data = '0; rob_head_tag = '0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
    #1;
    vectors++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_len, bus.mem_wdata, cdb_valid, cdb_tag, cdb_data, full} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h len=%0d wdata=%h cdb=%b/%h/%h full=%b, required all zero",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_len, bus.mem_wdata, cdb_valid, cdb_tag, cdb_data, full);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    logic [3:0]  ops   [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010};
    logic [31:0] bases [6] = '{32'h0000_00F0, 32'h0000_0204, 32'h0000_0210, 32'h0000_0220, 32'h0000_0230, 32'h0000_0240};
    logic [31:0] imms  [6] = '{32'h0000_0010, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] addrs [6] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0211, 32'h0000_0222, 32'h0000_0230, 32'h0000_0244};
    logic [2:0]  lens  [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4};
    logic [31:0] rds   [6] = '{32'h0000_0080, 32'hFFFF_FF7F, 32'h1234_5680, 32'h0000_8001, 32'hFFFF_8001, 32'h1234_5678};
    logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678};
    for (int i = 0; i < 6; i++) begin
      enqueue(ops[i], bases[i], imms[i], 32'h0, 4'(i + 5));
      serve("load", 1'b0, addrs[i], lens[i], 32'h0, rds[i]);
      expect_cdb("load", 1'b1, 4'(i + 5), exps[i]);
      tick();
      expect_cdb("load_pulse", 1'b0, 4'h0, 32'h0);
    end
  endtask

  task automatic test_stores();
    enqueue(4'b1010, 32'h200, 32'h0, 32'hDEAD_BEEF, 4'd3);
    expect_quiet("store_uncommitted", 10);
    commit = 1'b1; tick(); commit = 1'b0;
    serve("sw", 1'b1, 32'h200, 3'd4, 32'hDEAD_BEEF, 32'h0);
    expect_cdb("sw", 1'b0, 4'h0, 32'h0);
    commit = 1'b1;
    enqueue(4'b1000, 32'h300, 32'h2, 32'h1234_5678, 4'd4);
    commit = 1'b0;
    serve("sb", 1'b1, 32'h302, 3'd1, 32'h0000_0078, 32'h0);
    commit = 1'b1;
    enqueue(4'b1001, 32'h310, 32'h0, 32'hCAFE_F00D, 4'd6);
    commit = 1'b0;
    serve("sh", 1'b1, 32'h310, 3'd2, 32'h0000_F00D, 32'h0);
    expect_cdb("sh", 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_full_wrap();
    enqueue(4'b1010, 32'h700, 32'h0, 32'h1, 4'd1);
    enqueue(4'b1010, 32'h704, 32'h0, 32'h2, 4'd2);
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("FAIL full_at2: full=%b, required 0", full); end
    enqueue(4'b1010, 32'h708, 32'h0, 32'h3, 4'd3);
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("FAIL full_at3: full=%b, required 1", full); end
    commit = 1'b1; tick(); commit = 1'b0;
    serve("wrap_st1", 1'b1, 32'h700, 3'd4, 32'h1, 32'h0);
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("FAIL full_after_deq: full=%b, required 0", full); end
    commit = 1'b1; tick(); tick(); commit = 1'b0;
    serve("wrap_st2", 1'b1, 32'h704, 3'd4, 32'h2, 32'h0);
    serve("wrap_st3", 1'b1, 32'h708, 3'd4, 32'h3, 32'h0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++)
        enqueue(4'b0010, 32'h1000, 32'(4 * (r * 3 + k)), 32'h0, 4'(r * 3 + k));
      for (int k = 0; k < 3; k++) begin
        serve("wrap_ld", 1'b0, 32'h1000 + 32'(4 * (r * 3 + k)), 3'd4, 32'h0, 32'h0101_0101 * 32'(r * 3 + k));
        expect_cdb("wrap_ld", 1'b1, 4'(r * 3 + k), 32'h0101_0101 * 32'(r * 3 + k));
      end
    end
  endtask

  task automatic test_clear_stores();
    enqueue(4'b1010, 32'h400, 32'h0, 32'h1111_1111, 4'd1);
    enqueue(4'b1010, 32'h404, 32'h0, 32'h2222_2222, 4'd2);
    enqueue(4'b0010, 32'h500, 32'h0, 32'h0, 4'd3);
    enqueue(4'b0010, 32'h504, 32'h0, 32'h0, 4'd4);
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("FAIL clear_prefull: full=%b, required 1", full); end
    commit = 1'b1; tick();
    clear = 1'b1;
    enqueue(4'b0010, 32'h508, 32'h0, 32'h0, 4'd5);
    clear = 1'b0; commit = 1'b0;
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("FAIL clear_count: full=%b, required 0", full); end
    serve("clr_st1", 1'b1, 32'h400, 3'd4, 32'h1111_1111, 32'h0);
    expect_cdb("clr_st1", 1'b0, 4'h0, 32'h0);
    serve("clr_st2", 1'b1, 32'h404, 3'd4, 32'h2222_2222, 32'h0);
    expect_quiet("clr_loads_dropped", 10);
  endtask

  task automatic test_drain();
    enqueue(4'b0010, 32'h600, 32'h0, 32'h0, 4'd7);
    wait_req("drain");
    clear = 1'b1; tick(); clear = 1'b0;
    vectors++;
    if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL drain_req: mem_req=%b, required 0", bus.mem_req); end
    tick();
    bus.mem_rdata = 32'h55; bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    expect_cdb("drain_done", 1'b0, 4'h0, 32'h0);
    tick();
    expect_cdb("drain_after", 1'b0, 4'h0, 32'h0);
    bus.mem_done = 1'b1; tick(); bus.mem_done = 1'b0;
    expect_cdb("stray_done", 1'b0, 4'h0, 32'h0);
    enqueue(4'b0010, 32'h610, 32'h0, 32'h0, 4'd8);
    serve("post_drain", 1'b0, 32'h610, 3'd4, 32'h0, 32'h0000_00AA);
    expect_cdb("post_drain", 1'b1, 4'd8, 32'h0000_00AA);
  endtask

  task automatic test_invalid_and_rdy();
    enqueue(4'b0011, 32'h900, 32'h0, 32'h0, 4'd9);
    enqueue(4'b0010, 32'h904, 32'h0, 32'h0, 4'd10);
    serve("after_invalid", 1'b0, 32'h904, 3'd4, 32'h0, 32'h0000_0123);
    expect_cdb("after_invalid", 1'b1, 4'd10, 32'h0000_0123);
    rdy = 1'b0;
    enqueue(4'b0010, 32'h908, 32'h0, 32'h0, 4'd11);
    rdy = 1'b1;
    expect_quiet("rdy_low_ignored", 5);
  endtask

  task automatic test_io_order();
    rob_head_tag = 4'd5;
    enqueue(4'b0010, 32'h0003_0000, 32'h0, 32'h0, 4'd2);
`ifdef LSB_IO_ORDER_EN
    expect_quiet("io_blocked", 5);
    rob_head_tag = 4'd2;
    tick();
    vectors++;
    if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL io_release: mem_req=%b, required 1", bus.mem_req); end
`endif
    serve("io_load", 1'b0, 32'h0003_0000, 3'd4, 32'h0, 32'h0000_0777);
    expect_cdb("io_load", 1'b1, 4'd2, 32'h0000_0777);
    rob_head_tag = 4'd0;
  endtask

  task automatic test_reset_midrequest();
    enqueue(4'b0010, 32'hA00, 32'h0, 32'h0, 4'd12);
    wait_req("midreset");
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: req=%b addr=%h full=%b, required 0/0/0", bus.mem_req, bus.mem_addr, full);
    end
    tick();
    rst = 1'b1;
    expect_quiet("after_reset", 5);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_full_wrap();
    test_clear_stores();
    test_drain();
    test_invalid_and_rdy();
    test_io_order();
    test_reset_midrequest();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsb_queue.md
LSB_QUEUE -- requirements
Module: lsb_queue

Interface
REQ-001 Parameter DEPTH, default 16, queue entries; power of two, minimum 4.
REQ-002 Parameter TAG_W, default 4, ROB tag width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 rdy  in  1  global ready; when low, all state holds and inputs are ignored.
REQ-006 clear  in  1  misprediction flush.
REQ-007 in_valid, in_op[3:0] ({is_store, funct3}), in_base[31:0], in_imm[31:0], in_data[31:0], in_tag[TAG_W-1:0]  in  enqueue from dispatch.
REQ-008 full  out  1  queue cannot accept next cycle.
REQ-009 commit  in  1  ROB retires one store this cycle; rob_head_tag[TAG_W-1:0]  in  tag at ROB head.
REQ-010 mem_req, mem_we, mem_addr[31:0], mem_len[2:0] (1/2/4 bytes), mem_wdata[31:0]  out  request to memory controller.
REQ-011 mem_done  in  1, mem_rdata[31:0]  in  request completion.
REQ-012 cdb_valid  out  1, cdb_tag[TAG_W-1:0], cdb_data[31:0]  out  load result broadcast.

Function
REQ-013 Circular buffer, head/tail pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0; separate count register, 0..DEPTH.
REQ-014 Enqueue on in_valid writes op, addr = in_base+in_imm (mod 2^32), data, tag at tail; tail advances.
REQ-015 full = (count >= DEPTH-1), giving one-entry slack for in-flight dispatch; in_valid while count == DEPTH is dropped.
REQ-016 Simultaneous enqueue and dequeue leave count unchanged.
REQ-017 Committed-store counter cstore increments on commit, decrements on store completion; both together leave it unchanged.
REQ-018 FSM states IDLE, WAIT, DRAIN; only the head entry issues; one outstanding request.
REQ-019 IDLE -> WAIT when count>0 and the head is eligible: loads are always eligible; stores are eligible only when cstore>0. mem_req is registered, high the cycle after the decision.
REQ-020 mem_req and its fields are held stable through WAIT until mem_done; mem_req drops the cycle after mem_done.
REQ-021 mem_len: B/BU=1, H/HU=2, W=4; mem_wdata carries data masked to length, upper bits zero.
REQ-022 WAIT + mem_done on a load: dequeue, cdb_valid high one cycle, cdb_tag = entry tag; cdb_data sign-extended for B/H, zero-extended for BU/HU over the full 8/16 bits.
REQ-023 WAIT + mem_done on a store: dequeue, decrement cstore, no CDB broadcast.
REQ-024 Invalid funct3 at head: dequeue in one cycle with no memory request or broadcast.
REQ-025 clear: tail = head + cstore and count = cstore, so committed stores survive and all other entries are dropped. A same-cycle in_valid is ignored. A same-cycle commit is counted before truncation.
REQ-026 clear in WAIT with a load outstanding: go to DRAIN and drop mem_req. DRAIN ignores mem_rdata, makes no broadcast, and returns to IDLE on mem_done.
REQ-027 clear in WAIT with a store outstanding: the store completes normally.
REQ-028 mem_done outside WAIT is ignored.

Reset
REQ-029 rst low forces immediately: head=tail=count=cstore=0, FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_len=0, mem_wdata=0, cdb_valid=0, cdb_tag=0, cdb_data=0; full=0. Reset mid-request abandons it.

Configuration
REQ-030 Macro LSB_IO_ORDER_EN defined: a load whose addr[17:16]==2'b11 is eligible only when its tag equals rob_head_tag.
REQ-031 Macro LSB_IO_ORDER_EN absent: rob_head_tag is ignored and all loads are eligible at head.

Verification
REQ-032 Reset, enqueue LB to 0x100, mem_rdata=0x80 -> mem_len=1, cdb_data=0xFFFFFF80, correct tag, cdb_valid one cycle.
REQ-033 Enqueue SW 0xDEADBEEF to 0x200, no commit for 10 cycles -> mem_req stays 0; commit pulse -> mem_req with mem_we=1, mem_wdata=0xDEADBEEF.
REQ-034 DEPTH=4: enqueue 3 entries -> full=1; one dequeue -> full=0; pointer wrap over 12 ops keeps results in order.
REQ-035 Two committed stores plus two loads queued, then clear -> count=2, both stores still written, no load broadcast.
REQ-036 Load outstanding, clear, then mem_done=1 with rdata 0x55 -> cdb_valid stays 0, FSM back to IDLE.
REQ-037 With LSB_IO_ORDER_EN: LW to 0x30000, rob_head_tag mismatched -> no mem_req; tag matches -> mem_req next cycle.
